conv_acc_writer: RTL and testbench

CONV_ACC_WRITER -- requirements
Module: conv_acc_writer

---
 rtl/conv_acc_writer.sv | 180 ++++++++++++++++++
 tb/tb_conv_acc_writer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_acc_writer.sv
// Accumulator write-back stage for a convolution PE array.
// Folds per-pixel partial sums for six filters into six accumulator banks
// over S_f*N_ch passes. On the final pass it optionally applies ReLU.
`timescale 1ns/1ps
module conv_acc_writer #(
  parameter int M    = 32,
  parameter int Ma   = 16,
  parameter int S_f  = 5,
  parameter int RELU = 1
) (
  input  logic          clk,
  input  logic          rstp,
  input  logic          start,
  input  logic [Ma-1:0] S_in,
  input  logic [Ma-1:0] N_ch,
  input  logic          pv,
  input  logic [M-1:0]  Po1,
  input  logic [M-1:0]  Po2,
  input  logic [M-1:0]  Po3,
  input  logic [M-1:0]  Po4,
  input  logic [M-1:0]  Po5,
  input  logic [M-1:0]  Po6,
  output logic [Ma-1:0] Ra,
  input  logic [M-1:0]  Rd1,
  input  logic [M-1:0]  Rd2,
  input  logic [M-1:0]  Rd3,
  input  logic [M-1:0]  Rd4,
  input  logic [M-1:0]  Rd5,
  input  logic [M-1:0]  Rd6,
  output logic          We,
  output logic [Ma-1:0] Wa,
  output logic [M-1:0]  Wd1,
  output logic [M-1:0]  Wd2,
  output logic [M-1:0]  Wd3,
  output logic [M-1:0]  Wd4,
  output logic [M-1:0]  Wd5,
  output logic [M-1:0]  Wd6,
  output logic          busy,
  output logic          done,
  output logic [Ma-1:0] pass,
  output logic          err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [Ma-1:0] SF_W = Ma'(S_f);
  localparam logic [Ma-1:0] ONE  = Ma'(1);

  logic [1:0]    state;
  logic [Ma-1:0] cnt;
  logic [Ma-1:0] pass_q;
  logic [Ma-1:0] npix;
  logic [Ma-1:0] npass;
  logic          err_q;

  logic [Ma-1:0] s_c_o;
  logic [Ma-1:0] npix_new;
  logic [Ma-1:0] npass_new;
  logic          acc_go;
  logic          pix_wrap;
  logic          pass_end;

  logic          s1_valid;
  logic          s1_first;
  logic          s1_last;
  logic [Ma-1:0] s1_cnt;
  logic [M-1:0]  s1_po  [6];
  logic [M-1:0]  rd_in  [6];
  logic [M-1:0]  wd_out [6];

  assign rd_in[0] = Rd1;
  assign rd_in[1] = Rd2;
  assign rd_in[2] = Rd3;
  assign rd_in[3] = Rd4;
  assign rd_in[4] = Rd5;
  assign rd_in[5] = Rd6;

  // Layer geometry derived from the request and the current counter terminal conditions.
  always_comb begin
    s_c_o     = S_in - SF_W + ONE;
    npix_new  = s_c_o * s_c_o;
    npass_new = SF_W * N_ch;
    acc_go    = (state == ST_ACC) && pv;
    pix_wrap  = (cnt == npix - ONE);
    pass_end  = (pass_q == npass - ONE);
  end

  // Layer sequencing: pixel/pass counters, state, and the sticky stray-pv flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      pass_q <= '0;
      npix   <= '0;
      npass  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            npix   <= npix_new;
            npass  <= npass_new;
            cnt    <= '0;
            pass_q <= '0;
            err_q  <= 1'b0;
            state  <= (npass_new == '0) ? ST_DONE : ST_ACC;
          end
        end
        ST_ACC: begin
          if (pv) begin
            if (pix_wrap) begin
              cnt    <= '0;
              pass_q <= pass_q + ONE;
              if (pass_end) state <= ST_DRAIN;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        ST_DRAIN: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
      // A stray partial sum outside accumulation wins over the clear on start.
      if (pv && (state != ST_ACC)) err_q <= 1'b1;
    end
  end

  // Stage-1 valid: the only pipeline bit that must be cleared by reset.
  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) s1_valid <= 1'b0;
    else      s1_valid <= acc_go;
  end

  // Stage-1 payload, aligned with the accumulator read data returning next cycle.
  // NOTE: payload registers carry no reset; everything they drive is gated by s1_valid.
  always_ff @(posedge clk) begin
    if (acc_go) begin
      s1_cnt   <= cnt;
      s1_first <= (pass_q == '0);
      s1_last  <= pass_end;
      s1_po[0] <= Po1;
      s1_po[1] <= Po2;
      s1_po[2] <= Po3;
      s1_po[3] <= Po4;
      s1_po[4] <= Po5;
      s1_po[5] <= Po6;
    end
  end

  // Write-back datapath: seed or accumulate, ReLU on the final pass, zero when idle.
  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    logic [M-1:0] sum;
    sum = '0;
    We  = s1_valid;
    Wa  = s1_valid ? s1_cnt : '0;
    for (int k = 0; k < 6; k++) begin
      sum = s1_first ? s1_po[k] : (rd_in[k] + s1_po[k]);
      if ((RELU != 0) && s1_last && sum[M-1]) sum = '0;
      wd_out[k] = s1_valid ? sum : '0;
    end
  end

  assign Wd1  = wd_out[0];
  assign Wd2  = wd_out[1];
  assign Wd3  = wd_out[2];
  assign Wd4  = wd_out[3];
  assign Wd5  = wd_out[4];
  assign Wd6  = wd_out[5];
  assign Ra   = cnt;
  assign busy = (state == ST_ACC) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);
  assign pass = pass_q;
  assign err  = err_q;

endmodule

// File: tb/tb_conv_acc_writer.sv
// Self-checking bench for conv_acc_writer: directed stimulus pushes expected
// writes into a scoreboard queue, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_conv_acc_writer;

  logic        clk = 1'b0;
  logic        rstp;
  logic        start;
  logic [15:0] S_in, N_ch;
  logic        pv;
  logic [31:0] Po1, Po2, Po3, Po4, Po5, Po6;
  logic [15:0] Ra;
  logic [31:0] Rd1, Rd2, Rd3, Rd4, Rd5, Rd6;
  logic        We;
  logic [15:0] Wa;
  logic [31:0] Wd1, Wd2, Wd3, Wd4, Wd5, Wd6;
  logic        busy, done, err;
  logic [15:0] pass;

  conv_acc_writer dut (
    .clk(clk), .rstp(rstp), .start(start), .S_in(S_in), .N_ch(N_ch), .pv(pv),
    .Po1(Po1), .Po2(Po2), .Po3(Po3), .Po4(Po4), .Po5(Po5), .Po6(Po6),
    .Ra(Ra), .Rd1(Rd1), .Rd2(Rd2), .Rd3(Rd3), .Rd4(Rd4), .Rd5(Rd5), .Rd6(Rd6),
    .We(We), .Wa(Wa), .Wd1(Wd1), .Wd2(Wd2), .Wd3(Wd3), .Wd4(Wd4), .Wd5(Wd5), .Wd6(Wd6),
    .busy(busy), .done(done), .pass(pass), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned       cyc;
    logic [15:0]       wa;
    logic [5:0][31:0]  wd;
  } exp_t;

  exp_t             exp_q[$];
  logic [31:0]      a0_wd2_log[$];
  logic [5:0][31:0] obs [256];
  logic [5:0][31:0] mem [256];
  logic [5:0][31:0] em  [256];
  logic [5:0][31:0] rd_q;
  logic [5:0][31:0] wd_all;
  int               checks = 0;
  int               failures = 0;
  int unsigned      cyc = 0;
  int               b_cnt, b_pass, b_npix, b_npass;

  assign wd_all = {Wd6, Wd5, Wd4, Wd3, Wd2, Wd1};
  assign Rd1 = rd_q[0];
  assign Rd2 = rd_q[1];
  assign Rd3 = rd_q[2];
  assign Rd4 = rd_q[3];
  assign Rd5 = rd_q[4];
  assign Rd6 = rd_q[5];

  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator banks: synchronous read of Ra, write of Wa when We.
  always @(posedge clk) begin
    rd_q <= mem[Ra[7:0]];
    if (We) mem[Wa[7:0]] <= wd_all;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rstp && We) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", We, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("we_cycle", cyc, e.cyc);
        check("wa", Wa, e.wa);
        for (int k = 0; k < 6; k++) check($sformatf("wd%0d", k + 1), wd_all[k], e.wd[k]);
      end
      obs[Wa[7:0]] = wd_all;
      if (Wa == 16'd0) a0_wd2_log.push_back(Wd2);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_po(input logic [5:0][31:0] p);
    Po1 = p[0]; Po2 = p[1]; Po3 = p[2]; Po4 = p[3]; Po5 = p[4]; Po6 = p[5];
  endtask

  task automatic do_start(input int sin, input int nch);
    S_in  = 16'(sin);
    N_ch  = 16'(nch);
    start = 1'b1;
    tick(1);
    start   = 1'b0;
    b_cnt   = 0;
    b_pass  = 0;
    b_npix  = (sin - 4) * (sin - 4);
    b_npass = 5 * nch;
  endtask

  task automatic do_reset();
    rstp = 1'b1;
    tick(1);
    rstp = 1'b0;
    exp_q.delete();
  endtask

  // Drive one partial-sum cycle and queue the write it must produce one cycle later.
  task automatic send_pv(input logic [5:0][31:0] p);
    exp_t        e;
    logic [31:0] v;
    set_po(p);
    pv    = 1'b1;
    e.cyc = cyc + 1;
    e.wa  = 16'(b_cnt);
    for (int k = 0; k < 6; k++) begin
      v = (b_pass == 0) ? p[k] : em[b_cnt][k] + p[k];
      if ((b_pass == b_npass - 1) && v[31]) v = '0;
      em[b_cnt][k] = v;
      e.wd[k] = v;
    end
    exp_q.push_back(e);
    if (b_cnt == b_npix - 1) begin
      b_cnt = 0;
      b_pass++;
    end else begin
      b_cnt++;
    end
    tick(1);
    pv = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0][31:0] p;
    logic [31:0]      l3 [5];
    l3[0] = 32'hFFFF_FFFD; l3[1] = 32'hFFFF_FFFA; l3[2] = 32'hFFFF_FFF7;
    l3[3] = 32'hFFFF_FFF4; l3[4] = 32'h0000_0000;
    for (int a = 0; a < 256; a++) begin
      mem[a] = '0;
      obs[a] = '0;
      em[a]  = '0;
    end
    rstp = 1'b1; start = 1'b0; pv = 1'b0; S_in = '0; N_ch = '0;
    p = '0;
    set_po(p);
    #12;
    check("rst_we", We, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_pass", pass, 16'd0);
    check("rst_ra", Ra, 16'd0);
    check("rst_wa", Wa, 16'd0);
    check("rst_wd1", Wd1, 32'd0);
    @(posedge clk);
    #1;
    rstp = 1'b0;

    // Five passes of ones over a 2x2 output map.
    do_start(6, 1);
    for (int k = 0; k < 6; k++) p[k] = 32'd1;
    for (int i = 0; i < 20; i++) begin
      send_pv(p);
      if (i == 3) check("pass_after_4", pass, 16'd1);
    end
    check("drain_busy", busy, 1'b1);
    check("drain_done", done, 1'b0);
    tick(1);
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b0);
    tick(1);
    check("done_low", done, 1'b0);
    for (int a = 0; a < 4; a++)
      for (int k = 0; k < 6; k++) check($sformatf("ones_final_a%0d_k%0d", a, k), obs[a][k], 32'd5);

    // Negative accumulation on filter 2, clamped by ReLU on the final pass.
    a0_wd2_log.delete();
    do_start(6, 1);
    p = '0;
    p[1] = 32'hFFFF_FFFD;
    for (int i = 0; i < 20; i++) send_pv(p);
    tick(3);
    check("relu_log_len", a0_wd2_log.size(), 5);
    for (int i = 0; i < 5 && i < a0_wd2_log.size(); i++)
      check($sformatf("relu_wd2_pass%0d", i), a0_wd2_log[i], l3[i]);
    for (int a = 0; a < 4; a++) check($sformatf("relu_final_a%0d", a), obs[a][1], 32'd0);

    // Two's-complement wrap, then abort during pass 2 and restart.
    do_start(6, 1);
    p = '0;
    p[0] = 32'h7FFF_FFFF;
    for (int i = 0; i < 8; i++) send_pv(p);
    tick(2);
    for (int a = 0; a < 4; a++) check($sformatf("wrap_a%0d", a), obs[a][0], 32'hFFFF_FFFE);
    send_pv(p);
    check("pre_abort_we", We, 1'b1);
    rstp = 1'b1;
    #1;
    check("abort_we", We, 1'b0);
    check("abort_busy", busy, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rstp = 1'b0;
    tick(3);
    check("abort_no_done", done, 1'b0);
    check("abort_pass", pass, 16'd0);
    do_start(6, 1);
    for (int k = 0; k < 6; k++) p[k] = 32'(10 + k);
    for (int i = 0; i < 4; i++) send_pv(p);
    tick(2);
    check("restart_raw_a0_k0", obs[0][0], 32'd10);
    check("restart_raw_a3_k5", obs[3][5], 32'd15);
    do_reset();

    // Sparse pv: one partial sum every third cycle.
    do_start(6, 1);
    for (int k = 0; k < 6; k++) p[k] = 32'(k + 1);
    for (int i = 0; i < 20; i++) begin
      send_pv(p);
      if (i < 19) tick(2);
    end
    check("gap_drain_busy", busy, 1'b1);
    tick(1);
    check("gap_done", done, 1'b1);
    tick(1);
    for (int a = 0; a < 4; a++)
      for (int k = 0; k < 6; k++) check($sformatf("gap_final_a%0d_k%0d", a, k), obs[a][k], 32'(5 * (k + 1)));

    // Stray pv in IDLE raises err; the next start clears it.
    tick(2);
    pv = 1'b1;
    tick(1);
    pv = 1'b0;
    check("stray_err", err, 1'b1);
    check("stray_we", We, 1'b0);
    tick(1);
    check("stray_we_late", We, 1'b0);
    do_start(6, 1);
    check("start_clears_err", err, 1'b0);
    do_reset();

    // No channels: start goes straight to DONE without writes.
    do_start(6, 0);
    check("nch0_done", done, 1'b1);
    check("nch0_busy", busy, 1'b0);
    tick(1);
    check("nch0_done_low", done, 1'b0);

    tick(3);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
